// File: rtl/sd_cmd_serial_host_if.sv
// sd_cmd_serial_host_if: issuer <-> CMD-line PHY signal bundle.
// The master is the command issuer. The slave is the serializer.
// cmd_dat_i is driven by the card side of the CMD line.
interface sd_cmd_serial_host_if;
    logic [1:0]   setting_i;
    logic [39:0]  cmd_i;
    logic         start_xfr_i;
    logic [119:0] response_o;
    logic         crc_ok_o;
    logic         index_ok_o;
    logic         finish_o;
    logic         busy_o;
    logic         timeout_o;
    logic         cmd_dat_i;
    logic         cmd_dat_o;
    logic         cmd_oe_o;

    modport master (
        output setting_i, cmd_i, start_xfr_i, cmd_dat_i,
        input  response_o, crc_ok_o, index_ok_o, finish_o, busy_o, timeout_o,
               cmd_dat_o, cmd_oe_o
    );

    modport slave (
        input  setting_i, cmd_i, start_xfr_i, cmd_dat_i,
        output response_o, crc_ok_o, index_ok_o, finish_o, busy_o, timeout_o,
               cmd_dat_o, cmd_oe_o
    );
endinterface

// File: rtl/sd_cmd_serial_host.sv
// sd_cmd_serial_host: SD/eMMC CMD-line serializer.
// It sends a 48-bit command frame made of the command word, CRC7 and the end bit.
// It can also capture an R1-style (48-bit) or R2 (136-bit) response and check
// that response's CRC7 and index.
// Optional macro SD_CMD_RESP_TIMEOUT_EN bounds the wait for a response start bit.
module sd_cmd_serial_host #(
    parameter int NCC_CYCLES   = 8,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic                 sd_clk,
    input  logic                 sd_rst,
    sd_cmd_serial_host_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, TX, WAIT_RESP, RX, NCC, FIN} state_t;

    state_t       r_state, w_next;
    logic [1:0]   r_setting;
    logic [5:0]   r_idx;
    logic [47:0]  r_shift;
    logic [7:0]   r_cnt;
    logic [133:0] r_rx;
    logic [6:0]   r_crc;
    logic [119:0] r_resp;
    logic         r_crc_ok, r_idx_ok;
    logic [133:0] w_rx_next;
    logic         w_accept, w_rx_last, w_crc_in, w_to_expire;
    logic         w_unused;

    // Standard SD CRC7 (x^7+x^3+1), one bit per step, MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    assign w_accept  = (r_state == IDLE) && bus.start_xfr_i;
    // The frame bit at position p lands in w_rx_next[p]. The start bit at the
    // frame MSB is never stored.
    assign w_rx_next = {r_rx[132:0], bus.cmd_dat_i};
    // r_cnt counts bits already received, including the start bit.
    assign w_rx_last = (r_cnt == (r_setting[1] ? 8'd135 : 8'd47));
    // The CRC window for a short response is frame bits 46..8. The start bit is 0
    // and leaves a zero CRC unchanged, so it can be skipped. The window for a long
    // response is frame bits 127..8.
    assign w_crc_in  = r_setting[1] ? (r_cnt >= 8'd8 && r_cnt <= 8'd127)
                                    : (r_cnt <= 8'd39);
    assign w_unused  = ^{r_rx[133], w_rx_next[0]};

    assign bus.cmd_oe_o   = (r_state == TX);
    assign bus.cmd_dat_o  = (r_state == TX) ? r_shift[47] : 1'b1;
    assign bus.busy_o     = (r_state != IDLE);
    assign bus.finish_o   = (r_state == FIN);
    assign bus.response_o = r_resp;
    assign bus.crc_ok_o   = r_crc_ok;
    assign bus.index_ok_o = r_idx_ok;

    // State register
    always_ff @(posedge sd_clk or posedge sd_rst) begin
        if (sd_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic. In WAIT_RESP a start bit takes priority over a timeout expiry in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (bus.start_xfr_i) w_next = TX;
            TX:        if (r_cnt == 8'd47) w_next = r_setting[0] ? WAIT_RESP : NCC;
            WAIT_RESP: if (!bus.cmd_dat_i) w_next = RX;
                       else if (w_to_expire) w_next = FIN;
            RX:        if (w_rx_last) w_next = NCC;
            NCC:       if (r_cnt == 8'(NCC_CYCLES - 1)) w_next = FIN;
            FIN:       w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Datapath: latch the command, shift the frame out, shift the response in and grade it.
    always_ff @(posedge sd_clk or posedge sd_rst) begin
        if (sd_rst) begin
            r_setting <= 2'b00;
            r_idx     <= 6'd0;
            r_shift   <= '1;
            r_cnt     <= 8'd0;
            r_rx      <= '0;
            r_crc     <= 7'd0;
            r_resp    <= '0;
            r_crc_ok  <= 1'b0;
            r_idx_ok  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_setting <= bus.setting_i;
                    r_idx     <= bus.cmd_i[37:32];
                    r_shift   <= {bus.cmd_i, crc7_40(bus.cmd_i), 1'b1};
                    r_cnt     <= 8'd0;
                    r_crc_ok  <= 1'b0;
                    r_idx_ok  <= 1'b0;
                end
                TX: begin
                    r_shift <= {r_shift[46:0], 1'b1};
                    r_cnt   <= r_cnt + 8'd1;
                    if (r_cnt == 8'd47) begin
                        r_cnt <= 8'd0;
                        // With nothing to check, a no-response command is reported as clean.
                        if (!r_setting[0]) begin
                            r_crc_ok <= 1'b1;
                            r_idx_ok <= 1'b1;
                        end
                    end
                end
                WAIT_RESP: if (!bus.cmd_dat_i) begin
                    r_cnt <= 8'd1;
                    r_rx  <= '0;
                    r_crc <= 7'd0;
                end
                RX: begin
                    r_rx  <= w_rx_next;
                    r_cnt <= r_cnt + 8'd1;
                    if (w_crc_in) r_crc <= crc7_step(r_crc, bus.cmd_dat_i);
                    if (w_rx_last) begin
                        r_cnt    <= 8'd0;
                        r_crc_ok <= (r_crc == w_rx_next[7:1]);
                        if (r_setting[1]) begin
                            r_resp   <= w_rx_next[127:8];
                            r_idx_ok <= (w_rx_next[133:128] == 6'h3F);
                        end else begin
                            r_resp   <= {w_rx_next[39:8], 88'd0};
                            r_idx_ok <= (w_rx_next[45:40] == r_idx);
                        end
                    end
                end
                NCC:     r_cnt <= r_cnt + 8'd1;
                default: ;
            endcase
        end
    end

`ifdef SD_CMD_RESP_TIMEOUT_EN
    localparam int TO_W = $clog2(RESP_TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    assign w_to_expire   = (r_state == WAIT_RESP) && (r_to_cnt == TO_W'(RESP_TIMEOUT - 1));
    assign bus.timeout_o = r_timeout;

    // Count cycles spent in WAIT_RESP. The timeout flag is set on expiry and is held until the next accepted command.
    always_ff @(posedge sd_clk or posedge sd_rst) begin
        if (sd_rst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == WAIT_RESP) ? r_to_cnt + 1'b1 : '0;
            if (w_accept)                         r_timeout <= 1'b0;
            else if (w_to_expire && bus.cmd_dat_i) r_timeout <= 1'b1;
        end
    end
`else
    assign w_to_expire   = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_serial_host.sv
// tb_sd_cmd_serial_host: directed self-checking bench for sd_cmd_serial_host.
// Latency convention: if start_xfr_i is sampled at the end of cycle N, finish_o
// is expected 9 cycles after the last driven bit. For a no-response command that is cycle N+57.
module tb_sd_cmd_serial_host;
    logic sd_clk = 1'b0;
    logic sd_rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [39:0]  CMD0     = 40'h40_0000_0000;
    localparam logic [47:0]  CMD0_FRM = 48'h40_0000_0000_95;
    localparam logic [39:0]  CMD8     = 40'h48_0000_01AA;
    localparam logic [47:0]  CMD8_FRM = 48'h48_0000_01AA_87;
    localparam logic [39:0]  CMD3     = {2'b01, 6'd3, 32'h0000_1234};
    localparam logic [119:0] R2_BODY  = 120'h0123456789ABCDEF_FEDCBA98765432;

    logic [119:0] last_resp;

    sd_cmd_serial_host_if bus();

    sd_cmd_serial_host #(.NCC_CYCLES(8), .RESP_TIMEOUT(64)) dut (
        .sd_clk (sd_clk),
        .sd_rst (sd_rst),
        .bus    (bus)
    );

    always #5 sd_clk = ~sd_clk;

    task automatic tick();
        @(posedge sd_clk); #1;
    endtask

    // CRC7 computed by polynomial long division over the top-n message bits d[n-1:0].
    function automatic logic [6:0] crc7_model(input logic [119:0] d, input int n);
        logic [7:0] rem;
        rem = 8'h00;
        for (int i = n - 1; i >= -7; i--) begin
            rem = {rem[6:0], (i >= 0) ? d[i] : 1'b0};
            if (rem[7]) rem = rem ^ 8'h89;
        end
        return rem[6:0];
    endfunction

    // The task issues one command and records the transmitted frame and the number of cycles with cmd_oe_o high.
    // It then waits gap idle cycles, drives rlen response bits (MSB first), and returns the cycle index
    // of finish_o counted from the cycle after the last driven bit (-1 if finish_o does not occur).
    task automatic xfer(input logic [39:0] cmd, input logic [1:0] set, input logic [135:0] resp,
                        input int rlen, input int gap,
                        output logic [47:0] frame, output int oe_cnt, output int fin_dly);
        tick();
        bus.start_xfr_i = 1'b1; bus.cmd_i = cmd; bus.setting_i = set;
        tick();
        bus.start_xfr_i = 1'b0;
        oe_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            frame[47-i] = bus.cmd_dat_o;
            if (bus.cmd_oe_o === 1'b1) oe_cnt++;
            tick();
        end
        if (rlen > 0) begin
            for (int g = 0; g < gap; g++) tick();
            for (int i = 0; i < rlen; i++) begin
                bus.cmd_dat_i = resp[rlen-1-i];
                tick();
            end
            bus.cmd_dat_i = 1'b1;
        end
        fin_dly = -1;
        for (int k = 1; k <= 200; k++) begin
            if (fin_dly < 0) begin
                if (bus.finish_o === 1'b1) fin_dly = k;
                else tick();
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++; if (bus.cmd_oe_o !== 1'b0) $display("FAIL reset_oe got=%b exp=0", bus.cmd_oe_o); else n_pass++;
        n_checks++; if (bus.cmd_dat_o !== 1'b1) $display("FAIL reset_dat got=%b exp=1", bus.cmd_dat_o); else n_pass++;
        n_checks++; if ({bus.busy_o, bus.finish_o, bus.crc_ok_o, bus.index_ok_o, bus.timeout_o} !== 5'b0)
            $display("FAIL reset_flags got=%b exp=00000",
                     {bus.busy_o, bus.finish_o, bus.crc_ok_o, bus.index_ok_o, bus.timeout_o});
        else n_pass++;
        n_checks++; if (bus.response_o !== 120'd0) $display("FAIL reset_resp got=%h exp=0", bus.response_o); else n_pass++;
        sd_rst = 1'b0;
        tick();
    endtask

    task automatic test_cmd0();
        logic [47:0] frm; int oe, fd;
        xfer(CMD0, 2'b00, '0, 0, 0, frm, oe, fd);
        n_checks++; if (frm !== CMD0_FRM) $display("FAIL cmd0_frame got=%h exp=%h", frm, CMD0_FRM); else n_pass++;
        n_checks++; if (oe !== 48) $display("FAIL cmd0_oe_cycles got=%0d exp=48", oe); else n_pass++;
        n_checks++; if (fd !== 9) $display("FAIL cmd0_finish_at got=N+%0d exp=N+57", fd + 48); else n_pass++;
        n_checks++; if ({bus.crc_ok_o, bus.index_ok_o, bus.timeout_o} !== 3'b110)
            $display("FAIL cmd0_flags got=%b exp=110", {bus.crc_ok_o, bus.index_ok_o, bus.timeout_o}); else n_pass++;
        tick();
        n_checks++; if ({bus.finish_o, bus.busy_o} !== 2'b00)
            $display("FAIL cmd0_after_fin got=%b exp=00", {bus.finish_o, bus.busy_o}); else n_pass++;
    endtask

    task automatic test_cmd8();
        logic [47:0] frm; int oe, fd;
        xfer(CMD8, 2'b00, '0, 0, 0, frm, oe, fd);
        n_checks++; if (frm[7:0] !== 8'h87) $display("FAIL cmd8_crc_byte got=%h exp=87", frm[7:0]); else n_pass++;
        n_checks++; if (frm !== CMD8_FRM) $display("FAIL cmd8_frame got=%h exp=%h", frm, CMD8_FRM); else n_pass++;
        n_checks++; if (fd !== 9) $display("FAIL cmd8_finish got=%0d exp=9", fd); else n_pass++;
    endtask

    task automatic test_short_resp();
        logic [47:0] frm; logic [135:0] r1; logic [39:0] body; int oe, fd;
        body = {2'b00, 6'd3, 32'hC0FF_EE00};
        r1   = {88'd0, body, crc7_model({80'd0, body}, 40), 1'b1};
        xfer(CMD3, 2'b01, r1, 48, 5, frm, oe, fd);
        n_checks++; if (fd !== 9) $display("FAIL short_finish got=%0d exp=9", fd); else n_pass++;
        n_checks++; if (bus.response_o !== {32'hC0FF_EE00, 88'd0})
            $display("FAIL short_resp got=%h exp=%h", bus.response_o, {32'hC0FF_EE00, 88'd0}); else n_pass++;
        n_checks++; if ({bus.crc_ok_o, bus.index_ok_o} !== 2'b11)
            $display("FAIL short_ok got=%b exp=11", {bus.crc_ok_o, bus.index_ok_o}); else n_pass++;
        tick();
    endtask

    task automatic test_long_resp();
        logic [47:0] frm; logic [135:0] r2; logic [119:0] bad; int oe, fd;
        r2 = {2'b00, 6'h3F, R2_BODY, crc7_model(R2_BODY, 120), 1'b1};
        xfer(40'h42_0000_0000, 2'b11, r2, 136, 3, frm, oe, fd);
        n_checks++; if (fd !== 9) $display("FAIL long_finish got=%0d exp=9", fd); else n_pass++;
        n_checks++; if (bus.response_o !== R2_BODY) $display("FAIL long_resp got=%h exp=%h", bus.response_o, R2_BODY); else n_pass++;
        n_checks++; if ({bus.crc_ok_o, bus.index_ok_o} !== 2'b11)
            $display("FAIL long_ok got=%b exp=11", {bus.crc_ok_o, bus.index_ok_o}); else n_pass++;
        tick();
        bad = R2_BODY ^ (120'd1 << 50);
        r2  = {2'b00, 6'h3F, bad, crc7_model(R2_BODY, 120), 1'b1};
        xfer(40'h42_0000_0000, 2'b11, r2, 136, 3, frm, oe, fd);
        last_resp = bad;
        n_checks++; if ({bus.crc_ok_o, bus.index_ok_o} !== 2'b01)
            $display("FAIL long_badcrc got=%b exp=01", {bus.crc_ok_o, bus.index_ok_o}); else n_pass++;
        n_checks++; if (bus.response_o !== bad) $display("FAIL long_badresp got=%h exp=%h", bus.response_o, bad); else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        logic [47:0] frm; int oe, fd, fins;
        xfer(CMD3, 2'b01, '0, 0, 0, frm, oe, fd);
`ifdef SD_CMD_RESP_TIMEOUT_EN
        n_checks++; if (fd !== 65) $display("FAIL timeout_finish got=%0d exp=65", fd); else n_pass++;
        n_checks++; if ({bus.timeout_o, bus.crc_ok_o, bus.index_ok_o} !== 3'b100)
            $display("FAIL timeout_flags got=%b exp=100", {bus.timeout_o, bus.crc_ok_o, bus.index_ok_o}); else n_pass++;
        n_checks++; if (bus.response_o !== last_resp)
            $display("FAIL timeout_resp got=%h exp=%h", bus.response_o, last_resp); else n_pass++;
        tick();
`else
        fins = (fd >= 0) ? 1 : 0;
        for (int k = 0; k < 800; k++) begin
            if (bus.finish_o === 1'b1) fins++;
            tick();
        end
        n_checks++; if (fins !== 0) $display("FAIL no_timeout_finish got=%0d exp=0", fins); else n_pass++;
        n_checks++; if ({bus.busy_o, bus.timeout_o} !== 2'b10)
            $display("FAIL no_timeout_state got=%b exp=10", {bus.busy_o, bus.timeout_o}); else n_pass++;
        sd_rst = 1'b1; tick(); sd_rst = 1'b0; tick();
`endif
    endtask

    task automatic test_back_to_back();
        logic [47:0] frm; int fins; logic busy_after; logic seen;
        tick();
        bus.start_xfr_i = 1'b1; bus.cmd_i = CMD0; bus.setting_i = 2'b00;
        tick();
        bus.start_xfr_i = 1'b0;
        for (int i = 0; i < 48; i++) begin
            frm[47-i] = bus.cmd_dat_o;
            bus.start_xfr_i = (i == 10);
            bus.cmd_i = (i == 10) ? 40'h7F_FFFF_FFFF : CMD0;
            tick();
        end
        bus.start_xfr_i = 1'b0;
        fins = 0; seen = 1'b0; busy_after = 1'bx;
        for (int k = 0; k < 150; k++) begin
            if (bus.finish_o === 1'b1) begin fins++; bus.start_xfr_i = 1'b1; end
            else bus.start_xfr_i = 1'b0;
            tick();
            if (fins == 1 && !seen) begin seen = 1'b1; busy_after = bus.busy_o; end
        end
        bus.start_xfr_i = 1'b0;
        n_checks++; if (frm !== CMD0_FRM) $display("FAIL b2b_frame got=%h exp=%h", frm, CMD0_FRM); else n_pass++;
        n_checks++; if (fins !== 1) $display("FAIL b2b_finish_count got=%0d exp=1", fins); else n_pass++;
        n_checks++; if (busy_after !== 1'b0) $display("FAIL b2b_start_at_finish busy=%b exp=0", busy_after); else n_pass++;
    endtask

    task automatic test_reset_mid_rx();
        logic [47:0] frm; int oe, fd, fins; logic busy_before;
        tick();
        bus.start_xfr_i = 1'b1; bus.cmd_i = CMD3; bus.setting_i = 2'b01;
        tick();
        bus.start_xfr_i = 1'b0;
        repeat (50) tick();
        bus.cmd_dat_i = 1'b0;
        repeat (20) begin tick(); bus.cmd_dat_i = ~bus.cmd_dat_i; end
        busy_before = bus.busy_o;
        sd_rst = 1'b1; #1;
        n_checks++; if (busy_before !== 1'b1) $display("FAIL rst_rx_busy_before got=%b exp=1", busy_before); else n_pass++;
        n_checks++; if ({bus.cmd_oe_o, bus.busy_o, bus.finish_o} !== 3'b000)
            $display("FAIL rst_rx_state got=%b exp=000", {bus.cmd_oe_o, bus.busy_o, bus.finish_o}); else n_pass++;
        n_checks++; if (bus.response_o !== 120'd0) $display("FAIL rst_rx_resp got=%h exp=0", bus.response_o); else n_pass++;
        bus.cmd_dat_i = 1'b1;
        tick(); sd_rst = 1'b0;
        fins = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus.finish_o === 1'b1) fins++;
            tick();
        end
        n_checks++; if (fins !== 0) $display("FAIL rst_rx_finish got=%0d exp=0", fins); else n_pass++;
        xfer(CMD8, 2'b00, '0, 0, 0, frm, oe, fd);
        n_checks++; if (frm !== CMD8_FRM || fd !== 9)
            $display("FAIL post_rst_cmd frame=%h fin=%0d exp=%h/9", frm, fd, CMD8_FRM); else n_pass++;
    endtask

    initial begin
        sd_rst = 1'b1;
        bus.start_xfr_i = 1'b0; bus.cmd_i = '0; bus.setting_i = 2'b00; bus.cmd_dat_i = 1'b1;
        last_resp = '0;
        test_reset();
        test_cmd0();
        test_cmd8();
        test_short_resp();
        test_long_resp();
        test_timeout();
        test_back_to_back();
        test_reset_mid_rx();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
